seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode seven-segment driver.
// A binary value is accepted over a load/busy handshake, converted to BCD by
// a sequential double-dabble engine, committed to a display register and
// scanned one digit at a time.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int NUM_W     = 14,
  parameter int REFRESH_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NUM_W-1:0]  num,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg
);

  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int DISP_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(NUM_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last_shift;
  logic                 accept;
  logic                 shift_en;
  logic                 commit;

  logic [NUM_W-1:0]     shift_reg;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic                 ovf_next;
  logic [DISP_W-1:0]    disp;

  logic [REFRESH_W-1:0] refresh;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           digit;
  logic                 blank;
  logic [DIGITS-1:0]    anode_next;
  logic [6:0]           seg_next;

  assign last_shift = (cnt == CNT_W'(NUM_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a load outside IDLE (including COMMIT) is dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (last_shift) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake status and datapath strobes
  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && load;
    shift_en = (state == CONV);
    commit   = (state == COMMIT);
  end

  // Shift counter, committed display value and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      disp <= '0;
      ovf  <= 1'b0;
    end else begin
      if (accept)        cnt <= '0;
      else if (shift_en) cnt <= cnt + CNT_W'(1);
      if (commit) begin
        disp <= bcd[DISP_W-1:0];
        ovf  <= ovf_next;
      end
    end
  end

  // Double-dabble correction: +3 on every nibble that will reach 10 after the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; carries out of the top nibble only happen on overflow
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= num;
      bcd       <= '0;
      ovf_next  <= (64'(num) >= LIMIT);
    end else if (shift_en) begin
      bcd       <= (bcd_adj << 1) | BCD_W'(shift_reg[NUM_W-1]);
      shift_reg <= shift_reg << 1;
    end
  end

  // Refresh counter and digit index, free-running regardless of conversions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh <= '0;
      idx     <= '0;
    end else begin
      refresh <= refresh + REFRESH_W'(1);
      if (&refresh) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Select and decode the scanned digit; anode and segments derive from the same idx
  always_comb begin
    anode_next      = '1;
    anode_next[idx] = 1'b0;
    digit           = disp[4*int'(idx) +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx != '0) && !ovf;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'd0) blank = 1'b0;
    end
`else
    blank = 1'b0;
`endif
    if (ovf)        seg_next = 7'b1111110;
    else if (blank) seg_next = 7'b1111111;
    else            seg_next = decode_digit(digit);
  end

  // Output registers: anode and segments update together, never out of step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode <= ~DIGITS'(1);
      seg   <= 7'b0000001;
    end else begin
      anode <= anode_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (DIGITS=4, NUM_W=14, REFRESH_W=2).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [13:0] num;
  logic        busy;
  logic        ovf;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] DASH  = 7'b1111110;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ    = 7'b1111111;
`else
  localparam logic [6:0] LZ    = 7'b0000001;
`endif

  seg7_scan_driver #(.DIGITS(4), .NUM_W(14), .REFRESH_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .num   (num),
    .busy  (busy),
    .ovf   (ovf),
    .anode (anode),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_load(input logic [13:0] v);
    @(negedge clk);
    load = 1'b1;
    num  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk);
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp, input string name);
    logic [3:0] exp_an;
    int n;
    exp_an = ~(4'b0001 << d);
    n = 0;
    while (anode !== exp_an && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (anode !== exp_an) begin
      errors++;
      $display("FAIL %s_anode: got %b required %b", name, anode, exp_an);
    end else if (seg !== exp) begin
      errors++;
      $display("FAIL %s_seg: got %b required %b", name, seg, exp);
    end
  endtask

  task automatic check_busy_count(input int n, input int exp, input string name);
    checks++;
    if (n !== exp) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, n, exp);
    end
  endtask

  task automatic check_ovf(input logic exp, input string name);
    checks++;
    if (ovf !== exp) begin
      errors++;
      $display("FAIL %s_ovf: got %b required %b", name, ovf, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load  = 1'b0;
    num   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (anode !== 4'b1110) begin errors++; $display("FAIL reset_anode: got %b required 1110", anode); end
    checks++;
    if (seg !== S0) begin errors++; $display("FAIL reset_seg: got %b required %b", seg, S0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    check_ovf(1'b0, "reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_convert_1234;
    int n;
    start_load(14'd1234);
    wait_idle(n);
    check_busy_count(n, 15, "c1234");
    check_ovf(1'b0, "c1234");
    check_digit(3, S1, "c1234_d3");
    check_digit(2, S2, "c1234_d2");
    check_digit(1, S3, "c1234_d1");
    check_digit(0, S4, "c1234_d0");
  endtask

  task automatic test_scan_order;
    logic [3:0] exp_seq [3];
    logic [3:0] cur;
    int h;
    exp_seq[0] = 4'b1011;
    exp_seq[1] = 4'b0111;
    exp_seq[2] = 4'b1110;
    check_digit(0, S4, "scan_d0");
    check_digit(1, S3, "scan_d1");
    cur = anode;
    for (int k = 0; k < 3; k++) begin
      h = 0;
      while (anode === cur && h < 20) begin
        @(negedge clk);
        h++;
      end
      checks++;
      if (h !== 4) begin
        errors++;
        $display("FAIL scan_hold%0d: got %0d cycles required 4", k, h);
      end
      checks++;
      if (anode !== exp_seq[k]) begin
        errors++;
        $display("FAIL scan_order%0d: got %b required %b", k, anode, exp_seq[k]);
      end
      cur = anode;
    end
  endtask

  task automatic test_ovf;
    int n;
    start_load(14'd10000);
    wait_idle(n);
    check_ovf(1'b1, "o10000");
    for (int d = 0; d < 4; d++) check_digit(d, DASH, "o10000_dash");
    start_load(14'd9999);
    wait_idle(n);
    check_ovf(1'b0, "o9999");
    for (int d = 0; d < 4; d++) check_digit(d, S9, "o9999_nine");
  endtask

  task automatic test_back_to_back;
    int n;
    start_load(14'd42);
    @(negedge clk);
    load = 1'b1;
    num  = 14'd9999;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    check_busy_count(n, 13, "drop42");
    check_ovf(1'b0, "drop42");
    check_digit(3, LZ, "drop42_d3");
    check_digit(2, LZ, "drop42_d2");
    check_digit(1, S4, "drop42_d1");
    check_digit(0, S2, "drop42_d0");
    start_load(14'd123);
    repeat (14) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy: got %b required 1", busy); end
    load = 1'b1;
    num  = 14'd9999;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL commit_drop_busy: got %b required 0", busy); end
    wait_idle(n);
    check_digit(3, LZ, "c123_d3");
    check_digit(2, S1, "c123_d2");
    check_digit(1, S2, "c123_d1");
    check_digit(0, S3, "c123_d0");
  endtask

  task automatic test_leading_zero;
    int n;
    start_load(14'd7);
    wait_idle(n);
    check_digit(3, LZ, "n7_d3");
    check_digit(2, LZ, "n7_d2");
    check_digit(1, LZ, "n7_d1");
    check_digit(0, S7, "n7_d0");
    start_load(14'd0);
    wait_idle(n);
    check_digit(1, LZ, "n0_d1");
    check_digit(0, S0, "n0_d0");
  endtask

  task automatic test_reset_mid;
    int n;
    start_load(14'd9999);
    wait_idle(n);
    start_load(14'd1234);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    check_ovf(1'b0, "midrst");
    checks++;
    if (anode !== 4'b1110) begin errors++; $display("FAIL midrst_anode: got %b required 1110", anode); end
    checks++;
    if (seg !== S0) begin errors++; $display("FAIL midrst_seg: got %b required %b", seg, S0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL postrst_busy: got %b required 0", busy); end
    check_digit(3, LZ, "postrst_d3");
    check_digit(2, LZ, "postrst_d2");
    check_digit(1, LZ, "postrst_d1");
    check_digit(0, S0, "postrst_d0");
    start_load(14'd1234);
    wait_idle(n);
    check_busy_count(n, 15, "reload");
    check_digit(3, S1, "reload_d3");
    check_digit(0, S4, "reload_d0");
  endtask

  initial begin
    test_reset;
    test_convert_1234;
    test_scan_order;
    test_ovf;
    test_back_to_back;
    test_leading_zero;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
